// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: converts bit-reversed FFT output frames into natural order.
//
// Two N-entry banks, each holding {re, im}, form a ping-pong buffer. The write
// side stores sample k at address bitrev(k). The read side then streams a full
// bank out at addresses 0..N-1. Back-to-back frames flow with no idle cycles.
//
// Ports:
//   clock     master clock, rising edge
//   reset     synchronous, active-low
//   di_en     input sample valid
//   di_re/im  input sample, bit-reversed order
//   do_en     output sample valid
//   do_re/im  output sample, natural order (0 while do_en=0)
//   do_first  pulse coincident with X[0] of each frame
module fft_reorder_buf #(
    parameter int unsigned N     = 128,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             do_first
);

    localparam int unsigned LOG2N = $clog2(N);
    localparam logic [LOG2N-1:0] LastAddr = LOG2N'(N - 1);

    typedef enum logic [0:0] {StIdle, StRead} state_e;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    logic [2*WIDTH-1:0] mem [2][N];

    logic [LOG2N-1:0] wcnt_q;
    logic             wsel_q;
    logic [1:0]       full_q, full_d;
    logic             rsel_q, rsel_d;
    logic [LOG2N-1:0] rcnt_q, rcnt_d;
    state_e           state_q, state_d;

    logic             wr_done;
    logic             rd_issue;
    logic             rd_last;
    logic [LOG2N-1:0] raddr;
    logic             overflow;

    assign wr_done = di_en && (wcnt_q == LastAddr);

    // Read FSM: IDLE issues address 0 itself, so READ starts from rcnt=1.
    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        rsel_d   = rsel_q;
        rd_issue = 1'b0;
        rd_last  = 1'b0;
        raddr    = '0;
        unique case (state_q)
            StIdle: begin
                if (full_q[rsel_q]) begin
                    rd_issue = 1'b1;
                    raddr    = '0;
                    rcnt_d   = LOG2N'(1);
                    state_d  = StRead;
                end
            end
            StRead: begin
                rd_issue = 1'b1;
                raddr    = rcnt_q;
                rcnt_d   = rcnt_q + LOG2N'(1);
                if (rcnt_q == LastAddr) begin
                    rd_last = 1'b1;
                    rsel_d  = ~rsel_q;
                    rcnt_d  = '0;
                    // Continue straight into the other bank if it is, or is just
                    // becoming, full; otherwise wait in IDLE.
                    if (!(full_q[~rsel_q] || (wr_done && (wsel_q != rsel_q)))) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Clear before set so a read completion and a write completion on
    // different banks are both honoured.
    always_comb begin
        full_d = full_q;
        if (rd_last) full_d[rsel_q] = 1'b0;
        if (wr_done) full_d[wsel_q] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wcnt_q  <= '0;
            wsel_q  <= 1'b0;
            full_q  <= '0;
            rsel_q  <= 1'b0;
            rcnt_q  <= '0;
            state_q <= StIdle;
        end else begin
            if (di_en) wcnt_q <= wcnt_q + LOG2N'(1);
            if (wr_done) wsel_q <= ~wsel_q;
            full_q  <= full_d;
            rsel_q  <= rsel_d;
            rcnt_q  <= rcnt_d;
            state_q <= state_d;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clock) begin
        if (reset && di_en) begin
            mem[wsel_q][bitrev(wcnt_q)] <= {di_re, di_im};
        end
    end

    // Synchronous read doubles as the output register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            do_en    <= 1'b0;
            do_first <= 1'b0;
            do_re    <= '0;
            do_im    <= '0;
        end else begin
            do_en    <= rd_issue;
            do_first <= rd_issue && (raddr == '0);
            if (rd_issue) begin
                {do_re, do_im} <= mem[rsel_q][raddr];
            end else begin
                do_re <= '0;
                do_im <= '0;
            end
        end
    end

    // A frame completing into a bank whose readout has not been fully issued.
    assign overflow = wr_done && full_q[wsel_q] && !(rd_last && (rsel_q == wsel_q));

    overflow_a: assert property (@(posedge clock) disable iff (!reset) !overflow);

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Bench for fft_reorder_buf: scoreboard of natural-order frames, plus latency,
// burst-length and reset behaviour checks.
module tb_fft_reorder_buf;

    localparam int N = 128;
    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         di_en = 1'b0;
    logic [W-1:0] di_re = '0;
    logic [W-1:0] di_im = '0;
    logic         do_en;
    logic [W-1:0] do_re;
    logic [W-1:0] do_im;
    logic         do_first;

    fft_reorder_buf #(.N(N), .WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .di_en    (di_en),
        .di_re    (di_re),
        .di_im    (di_im),
        .do_en    (do_en),
        .do_re    (do_re),
        .do_im    (do_im),
        .do_first (do_first)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef logic [2*W:0] exp_t;  // {first, re, im}
    exp_t q[$];

    int errors = 0;
    int checks = 0;
    int last_drv_cyc = 0;
    int exp_burst = N;
    int run = 0;
    bit prev_en = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int bitrev7(input int k);
        int r = 0;
        for (int i = 0; i < 7; i++) begin
            if (k[i]) r |= (1 << (6 - i));
        end
        return r;
    endfunction

    // Output monitor, sampling on the falling edge.
    always @(negedge clock) begin
        exp_t e;
        if (do_en) begin
            if (q.size() == 0) begin
                check_eq("unexpected_do_en", 64'(do_en), 64'd0);
            end else begin
                e = q.pop_front();
                check_eq("do_re", 64'(do_re), 64'(e[2*W-1:W]));
                check_eq("do_im", 64'(do_im), 64'(e[W-1:0]));
                check_eq("do_first", 64'(do_first), 64'(e[2*W]));
            end
            if (!prev_en && reset) check_eq("latency", 64'(cyc - last_drv_cyc), 64'd2);
            run++;
        end else begin
            check_eq("idle_data_zero", 64'({do_re, do_im}), 64'd0);
            check_eq("idle_first_zero", 64'(do_first), 64'd0);
            if (prev_en && reset) check_eq("burst_len", 64'(run), 64'(exp_burst));
            run = 0;
        end
        prev_en = do_en;
        if (!reset) begin
            run = 0;
            prev_en = 1'b0;
        end
    end

    // Drives nsamp samples of a frame in bit-reversed order; a complete frame
    // pushes its natural-order expectation. di_en is left high at the end.
    task automatic send_frame(input int id, input bit gap, input bit impulse, input int nsamp);
        exp_t fr[N];
        logic [W-1:0] re, im;
        int n;
        for (int k = 0; k < nsamp; k++) begin
            n = bitrev7(k);
            if (impulse) begin
                re = 16'h7FFF >> 7;  // unit impulse through a 1/N-scaled FFT
                im = '0;
            end else begin
                re = W'(id * 256 + n);
                im = -re;
            end
            @(negedge clock);
            di_en = 1'b1;
            di_re = re;
            di_im = im;
            fr[n] = {(n == 0), re, im};
            if (gap && k != nsamp - 1) begin
                @(negedge clock);
                di_en = 1'b0;
            end
        end
        if (nsamp == N) begin
            last_drv_cyc = cyc;
            for (int i = 0; i < N; i++) q.push_back(fr[i]);
        end
    endtask

    task automatic idle_input();
        @(negedge clock);
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while (i < 1000 && (q.size() != 0 || do_en)) begin
            @(negedge clock);
            i++;
        end
        check_eq(tag, 64'(q.size()), 64'd0);
        repeat (4) @(negedge clock);
    endtask

    initial begin
        bit hit;
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_eq("rst_do_en", 64'(do_en), 64'd0);
        check_eq("rst_do_first", 64'(do_first), 64'd0);
        check_eq("rst_do_re", 64'(do_re), 64'd0);
        check_eq("rst_do_im", 64'(do_im), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // 1: single frame, ramp
        exp_burst = N;
        send_frame(0, 1'b0, 1'b0, N);
        idle_input();
        drain("t1_drain");

        // 2: three back-to-back frames
        exp_burst = 3 * N;
        send_frame(1, 1'b0, 1'b0, N);
        send_frame(2, 1'b0, 1'b0, N);
        send_frame(3, 1'b0, 1'b0, N);
        idle_input();
        drain("t2_drain");

        // 3: gapped input
        exp_burst = N;
        send_frame(6, 1'b1, 1'b0, N);
        idle_input();
        drain("t3_drain");

        // 4: reset mid-input, then a full frame
        send_frame(7, 1'b0, 1'b0, 50);
        idle_input();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        send_frame(4, 1'b0, 1'b0, N);
        idle_input();
        drain("t4_drain");

        // 5: reset while output index 40 is presented
        send_frame(5, 1'b0, 1'b0, N);
        idle_input();
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(posedge clock);
            #1;
            if (do_en && do_re[7:0] == 8'd40) hit = 1'b1;
        end
        check_eq("t5_reach_idx40", 64'(hit), 64'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        q.delete();
        check_eq("t5_do_en", 64'(do_en), 64'd0);
        check_eq("t5_do_re", 64'(do_re), 64'd0);
        check_eq("t5_do_im", 64'(do_im), 64'd0);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (300) @(negedge clock);
        check_eq("t5_no_resume", 64'(do_en), 64'd0);

        // 6: impulse response of the FFT, all bins equal
        exp_burst = N;
        send_frame(0, 1'b0, 1'b1, N);
        idle_input();
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
